// File: rtl/fifo_cfg_if.sv
// Handshake/status bundle between a streaming producer/consumer and fifo_cfg.
// The FIFO takes the slave side; the producer/consumer logic takes the master side.
interface fifo_cfg_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
);
    logic [DWIDTH-1:0] data_i;
    logic              wrreq_i;
    logic              rdreq_i;
    logic              thr_we_i;
    logic [AWIDTH:0]   af_thr_i;
    logic [AWIDTH:0]   ae_thr_i;
    logic              err_clr_i;
    logic [DWIDTH-1:0] q_o;
    logic [AWIDTH:0]   usedw_o;
    logic              empty_o;
    logic              full_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic              overflow_o;
    logic              underflow_o;

    modport master (
        output data_i, wrreq_i, rdreq_i, thr_we_i, af_thr_i, ae_thr_i, err_clr_i,
        input  q_o, usedw_o, empty_o, full_o, almost_full_o, almost_empty_o,
               overflow_o, underflow_o
    );

    modport slave (
        input  data_i, wrreq_i, rdreq_i, thr_we_i, af_thr_i, ae_thr_i, err_clr_i,
        output q_o, usedw_o, empty_o, full_o, almost_full_o, almost_empty_o,
               overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_cfg.sv
// Single-clock FIFO with showahead/normal read mode, optional read-write when full,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_cfg #(
    parameter int DWIDTH             = 8,
    parameter int AWIDTH             = 4,
    parameter int SHOWAHEAD          = 1,
    parameter int ALLOW_RW_WHEN_FULL = 0,
    parameter int ALMOST_FULL_VALUE  = 12,
    parameter int ALMOST_EMPTY_VALUE = 4
) (
    input  logic       clk_i,
    input  logic       srst_i,
    fifo_cfg_if.slave  bus
);
    localparam int              DEPTH   = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] ONE_W   = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] AF_RST  = (AWIDTH+1)'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0] AE_RST  = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] q;
    logic [AWIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AWIDTH:0]   usedw, usedw_nxt;
    logic [AWIDTH:0]   af_thr, ae_thr;
    logic              empty, full, almost_full, almost_empty;
    logic              overflow, underflow;
    logic              wr_acc, rd_acc, empty_nxt;

    always_comb begin
        rd_acc     = bus.rdreq_i && !empty;
        wr_acc     = bus.wrreq_i && (!full || ((ALLOW_RW_WHEN_FULL != 0) && rd_acc));
        rd_ptr_nxt = rd_ptr + AWIDTH'(rd_acc);
        usedw_nxt  = usedw;
        if (wr_acc && !rd_acc) begin
            usedw_nxt = usedw + ONE_W;
        end else if (rd_acc && !wr_acc) begin
            usedw_nxt = usedw - ONE_W;
        end
        // In showahead mode a head word written this edge is not readable out of
        // the RAM until the next edge, so it is not yet valid on q_o.
        empty_nxt = (usedw_nxt == '0) ||
                    ((SHOWAHEAD != 0) && wr_acc && (usedw_nxt == ONE_W));
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc && !srst_i) begin
            mem[wr_ptr] <= bus.data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (SHOWAHEAD != 0) begin
            q <= mem[rd_ptr_nxt];
        end else if (rd_acc && !srst_i) begin
            q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= (AF_RST == '0);
            almost_empty <= (AE_RST != '0);
            af_thr       <= AF_RST;
            ae_thr       <= AE_RST;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AWIDTH'(1);
            end
            rd_ptr       <= rd_ptr_nxt;
            usedw        <= usedw_nxt;
            empty        <= empty_nxt;
            full         <= (usedw_nxt == DEPTH_W);
            almost_full  <= (usedw_nxt >= af_thr);
            almost_empty <= (usedw_nxt < ae_thr);
            if (bus.thr_we_i) begin
                af_thr <= bus.af_thr_i;
                ae_thr <= bus.ae_thr_i;
            end
            // A new error wins over a simultaneous clear.
            overflow  <= (bus.wrreq_i && !wr_acc) || (overflow && !bus.err_clr_i);
            underflow <= (bus.rdreq_i && !rd_acc) || (underflow && !bus.err_clr_i);
        end
    end

    assign bus.q_o            = q;
    assign bus.usedw_o        = usedw;
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.almost_full_o  = almost_full;
    assign bus.almost_empty_o = almost_empty;
    assign bus.overflow_o     = overflow;
    assign bus.underflow_o    = underflow;
endmodule

// File: tb/tb_fifo_cfg.sv
// Bench for fifo_cfg: three instances (showahead, showahead + rw-when-full, normal + rw-when-full)
// share one stimulus stream; directed vectors plus a per-cycle reference model.
module tb_fifo_cfg;
    logic       clk = 1'b0;
    logic       srst, wrreq, rdreq, thr_we, err_clr;
    logic [7:0] data;
    logic [4:0] af_thr, ae_thr;

    logic [7:0] o_q     [3];
    logic [4:0] o_usedw [3];
    logic       o_empty [3];
    logic       o_full  [3];
    logic       o_af    [3];
    logic       o_ae    [3];
    logic       o_ovf   [3];
    logic       o_udf   [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fifo_cfg_if #(.DWIDTH(8), .AWIDTH(4)) bus ();
        assign bus.data_i    = data;
        assign bus.wrreq_i   = wrreq;
        assign bus.rdreq_i   = rdreq;
        assign bus.thr_we_i  = thr_we;
        assign bus.af_thr_i  = af_thr;
        assign bus.ae_thr_i  = ae_thr;
        assign bus.err_clr_i = err_clr;
        assign o_q[g]     = bus.q_o;
        assign o_usedw[g] = bus.usedw_o;
        assign o_empty[g] = bus.empty_o;
        assign o_full[g]  = bus.full_o;
        assign o_af[g]    = bus.almost_full_o;
        assign o_ae[g]    = bus.almost_empty_o;
        assign o_ovf[g]   = bus.overflow_o;
        assign o_udf[g]   = bus.underflow_o;
        fifo_cfg #(
            .DWIDTH(8), .AWIDTH(4),
            .SHOWAHEAD(g < 2 ? 1 : 0),
            .ALLOW_RW_WHEN_FULL(g == 0 ? 0 : 1),
            .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(4)
        ) u_dut (
            .clk_i (clk),
            .srst_i(srst),
            .bus   (bus)
        );
    end

    // Reference model: circular store with a per-word write stamp (edge number).
    logic [7:0] m_dat   [3][16];
    int         m_stamp [3][16];
    int         m_head [3], m_cnt [3], m_afthr [3], m_aethr [3];
    bit         m_ovf [3], m_udf [3], m_full [3], m_af [3], m_ae [3], m_empty [3], m_qv [3];
    logic [7:0] m_q [3];
    int         ecnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    task automatic m_step();
        bit rd, wr, sa, rw;
        int widx;
        ecnt++;
        for (int i = 0; i < 3; i++) begin
            sa = (i < 2);
            rw = (i != 0);
            if (srst) begin
                m_cnt[i] = 0; m_head[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
                m_afthr[i] = 12; m_aethr[i] = 4;
                m_full[i] = 0; m_af[i] = 0; m_ae[i] = 1; m_empty[i] = 1;
            end else begin
                rd   = rdreq && !m_empty[i];
                wr   = wrreq && (m_cnt[i] < 16 || (rw && rd));
                widx = (m_head[i] + m_cnt[i]) % 16;
                if (rd) begin
                    if (!sa) begin
                        m_q[i]  = m_dat[i][m_head[i]];
                        m_qv[i] = 1;
                    end
                    m_head[i] = (m_head[i] + 1) % 16;
                    m_cnt[i]--;
                end
                if (wr) begin
                    m_dat[i][widx]   = data;
                    m_stamp[i][widx] = ecnt;
                    m_cnt[i]++;
                end
                m_ovf[i]  = (wrreq && !wr) ? 1'b1 : (err_clr ? 1'b0 : m_ovf[i]);
                m_udf[i]  = (rdreq && !rd) ? 1'b1 : (err_clr ? 1'b0 : m_udf[i]);
                m_full[i] = (m_cnt[i] == 16);
                m_af[i]   = (m_cnt[i] >= m_afthr[i]);
                m_ae[i]   = (m_cnt[i] < m_aethr[i]);
                if (thr_we) begin
                    m_afthr[i] = int'(af_thr);
                    m_aethr[i] = int'(ae_thr);
                end
                if (sa) m_empty[i] = !(m_cnt[i] > 0 && m_stamp[i][m_head[i]] < ecnt);
                else    m_empty[i] = (m_cnt[i] == 0);
            end
        end
    endtask

    task automatic m_cmp();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_usedw", i), 32'(o_usedw[i]), 32'(m_cnt[i]));
            check($sformatf("u%0d_empty", i), 32'(o_empty[i]), 32'(m_empty[i]));
            check($sformatf("u%0d_full", i),  32'(o_full[i]),  32'(m_full[i]));
            check($sformatf("u%0d_af", i),    32'(o_af[i]),    32'(m_af[i]));
            check($sformatf("u%0d_ae", i),    32'(o_ae[i]),    32'(m_ae[i]));
            check($sformatf("u%0d_ovf", i),   32'(o_ovf[i]),   32'(m_ovf[i]));
            check($sformatf("u%0d_udf", i),   32'(o_udf[i]),   32'(m_udf[i]));
            if (i < 2 && !m_empty[i])
                check($sformatf("u%0d_q", i), 32'(o_q[i]), 32'(m_dat[i][m_head[i]]));
            if (i == 2 && m_qv[i])
                check($sformatf("u%0d_q", i), 32'(o_q[i]), 32'(m_q[i]));
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        m_cmp();
    endtask

    task automatic idle();
        srst = 0; wrreq = 0; rdreq = 0; thr_we = 0; err_clr = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        idle();
        wrreq = 1;
        data  = d;
        tick();
    endtask

    initial begin
        int rdp;
        idle();
        data = '0; af_thr = '0; ae_thr = '0;
        for (int i = 0; i < 3; i++) m_qv[i] = 0;
        srst = 1;
        tick();
        tick();
        idle();
        check("rst_usedw", 32'(o_usedw[0]), 0);
        check("rst_empty", 32'(o_empty[0]), 1);
        check("rst_full",  32'(o_full[0]),  0);
        check("rst_af",    32'(o_af[0]),    0);
        check("rst_ae",    32'(o_ae[0]),    1);
        check("rst_ovf",   32'(o_ovf[0]),   0);
        check("rst_udf",   32'(o_udf[0]),   0);

        // fill 0x01..0x10
        for (int k = 1; k <= 16; k++) begin
            wr(8'(k));
            check("fill_usedw", 32'(o_usedw[0]), 32'(k));
            check("fill_af",    32'(o_af[0]),    32'(k >= 12));
            check("fill_ae",    32'(o_ae[0]),    32'(k < 4));
            check("fill_full",  32'(o_full[0]),  32'(k == 16));
            if (k == 1) begin
                check("sa_empty_wr1", 32'(o_empty[0]), 1);
                check("nm_empty_wr1", 32'(o_empty[2]), 0);
            end
            if (k == 2) begin
                check("sa_empty_wr2", 32'(o_empty[0]), 0);
                check("sa_q_wr2",     32'(o_q[0]),     32'h01);
            end
        end
        wr(8'h11);
        check("ovf_set",      32'(o_ovf[0]),   1);
        check("ovf_usedw",    32'(o_usedw[0]), 16);
        check("ovf_set_rw",   32'(o_ovf[1]),   1);
        idle(); err_clr = 1; tick();
        check("ovf_clr", 32'(o_ovf[0]), 0);

        // read-write when full
        idle(); wrreq = 1; rdreq = 1; data = 8'hAA; tick();
        check("rwf_q",      32'(o_q[1]),     32'h02);
        check("rwf_usedw",  32'(o_usedw[1]), 16);
        check("rwf_ovf",    32'(o_ovf[1]),   0);
        check("norw_usedw", 32'(o_usedw[0]), 15);
        check("norw_ovf",   32'(o_ovf[0]),   1);
        check("nm_rwf_q",   32'(o_q[2]),     32'h01);
        for (int j = 0; j < 16; j++) begin
            check("drain_q", 32'(o_q[1]), (j < 15) ? 32'(j + 2) : 32'hAA);
            idle(); rdreq = 1; tick();
        end
        check("drain_usedw", 32'(o_usedw[1]), 0);
        check("drain_empty", 32'(o_empty[1]), 1);
        check("drain_udf",   32'(o_udf[0]),   1);

        // underflow and clear
        idle(); err_clr = 1; tick();
        check("udf_clr0", 32'(o_udf[0]), 0);
        idle(); rdreq = 1; tick();
        check("udf_set", 32'(o_udf[0]), 1);
        idle(); err_clr = 1; tick();
        check("udf_clr", 32'(o_udf[0]), 0);
        idle(); err_clr = 1; rdreq = 1; tick();
        check("udf_set_wins", 32'(o_udf[0]), 1);

        // runtime thresholds af=4 ae=2
        idle(); thr_we = 1; af_thr = 5'd4; ae_thr = 5'd2; tick();
        check("thr_af0", 32'(o_af[0]), 0);
        check("thr_ae0", 32'(o_ae[0]), 1);
        for (int k = 1; k <= 4; k++) begin
            wr(8'(8'h20 + k));
            check("thr_af", 32'(o_af[0]), 32'(k >= 4));
            check("thr_ae", 32'(o_ae[0]), 32'(k < 2));
        end
        for (int k = 0; k < 4; k++) begin
            idle(); rdreq = 1; tick();
        end
        check("thr_drain", 32'(o_usedw[0]), 0);
        idle(); err_clr = 1; tick();

        // showahead vs normal latency
        wr(8'h5A);
        check("lat_sa_empty_n", 32'(o_empty[0]), 1);
        check("lat_nm_empty_n", 32'(o_empty[2]), 0);
        check("lat_usedw_n",    32'(o_usedw[0]), 1);
        idle(); rdreq = 1; tick();
        check("lat_nm_q",     32'(o_q[2]),     32'h5A);
        check("lat_nm_empty", 32'(o_empty[2]), 1);
        check("lat_sa_q",     32'(o_q[0]),     32'h5A);
        check("lat_sa_empty", 32'(o_empty[0]), 0);
        check("lat_sa_udf",   32'(o_udf[0]),   1);
        idle(); wrreq = 1; rdreq = 1; data = 8'h77; tick();
        check("wr1_empty", 32'(o_empty[0]), 1);
        check("wr1_usedw", 32'(o_usedw[0]), 1);
        idle(); tick();
        check("wr1_empty_n1", 32'(o_empty[0]), 0);
        check("wr1_q_n1",     32'(o_q[0]),     32'h77);
        idle(); rdreq = 1; tick();
        idle(); err_clr = 1; tick();

        // reset while half-full, with requests in the reset cycle
        for (int k = 0; k < 8; k++) wr(8'(8'h30 + k));
        idle(); srst = 1; wrreq = 1; rdreq = 1; data = 8'hEE; tick();
        check("mrst_usedw", 32'(o_usedw[0]), 0);
        check("mrst_empty", 32'(o_empty[0]), 1);
        check("mrst_full",  32'(o_full[0]),  0);
        check("mrst_af",    32'(o_af[0]),    0);
        check("mrst_ae",    32'(o_ae[0]),    1);
        check("mrst_ovf",   32'(o_ovf[0]),   0);
        check("mrst_udf",   32'(o_udf[0]),   0);
        check("mrst_nm_usedw", 32'(o_usedw[2]), 0);
        idle(); tick();
        check("mrst_after", 32'(o_usedw[0]), 0);

        // random traffic: read 25/50/75 percent
        for (int mix = 0; mix < 3; mix++) begin
            rdp = 25 + 25 * mix;
            for (int c = 0; c < 1000; c++) begin
                idle();
                wrreq   = ($urandom_range(0, 99) < 32'(100 - rdp));
                rdreq   = ($urandom_range(0, 99) < 32'(rdp));
                data    = 8'($urandom);
                thr_we  = ($urandom_range(0, 63) == 0);
                af_thr  = 5'($urandom_range(0, 31));
                ae_thr  = 5'($urandom_range(0, 31));
                err_clr = ($urandom_range(0, 31) == 0);
                srst    = ($urandom_range(0, 499) == 0);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_cfg.md
# fifo_cfg

Single-clock, parametrised synchronous FIFO; the next generation of the team's `fifo` block. It adds a selectable read mode (showahead or normal), an optional read-write cycle when full, runtime-programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between a streaming producer and consumer in the same clock domain. With `SHOWAHEAD=1`, `ALLOW_RW_WHEN_FULL=0` and thresholds left at reset values, it is cycle-equivalent to `fifo`.

## Interface
- `DWIDTH`, 8: data word width.
- `AWIDTH`, 4: address width; depth = 2**AWIDTH words.
- `SHOWAHEAD`, 1: 1 = head word presented on `q_o` without a read; 0 = normal mode, `q_o` updates after a read.
- `ALLOW_RW_WHEN_FULL`, 0: 1 = a write is accepted when full if a read is accepted in the same cycle.
- `ALMOST_FULL_VALUE`, 12: reset value of the almost-full threshold.
- `ALMOST_EMPTY_VALUE`, 4: reset value of the almost-empty threshold.

Ports:
- `clk_i` in 1: clock. One clock domain; all logic is on the rising edge.
- `srst_i` in 1: reset, synchronous, active-high.
- `data_i` in DWIDTH: write data.
- `wrreq_i` in 1: write request.
- `rdreq_i` in 1: read request, acknowledge style.
- `thr_we_i` in 1: load both thresholds.
- `af_thr_i` in AWIDTH+1: new almost-full threshold.
- `ae_thr_i` in AWIDTH+1: new almost-empty threshold.
- `err_clr_i` in 1: clear the sticky error flags.
- `q_o` out DWIDTH: read data.
- `usedw_o` out AWIDTH+1: stored word count, range 0..2**AWIDTH.
- `empty_o`, `full_o`, `almost_full_o`, `almost_empty_o` out 1: status flags.
- `overflow_o`, `underflow_o` out 1: sticky error flags.

## Operation
**Storage**
- Dual-port RAM of 2**AWIDTH × DWIDTH.
- Write and read pointers are AWIDTH bits and wrap modulo depth.
- `usedw_o` is a separate AWIDTH+1-bit counter.

**Write and read acceptance**
- Write accepted when `wrreq_i` and (`!full_o`, or `ALLOW_RW_WHEN_FULL` and read accepted).
- Read accepted when `rdreq_i` and `!empty_o`.
- Simultaneous accepted read and write: `usedw_o` is unchanged and both pointers advance.
- Rejected write with `wrreq_i=1`: sets `overflow_o`; storage and pointers are unchanged.
- Rejected read with `rdreq_i=1`: sets `underflow_o`; state is unchanged.

**Error flags**
- Sticky until `err_clr_i` or `srst_i`.
- When clear and a new error coincide, set wins.

**Flag definitions**
- `full_o` = (`usedw_o` == 2**AWIDTH).
- `almost_full_o` = (`usedw_o` >= af_thr).
- `almost_empty_o` = (`usedw_o` < ae_thr).
- All flags are registered and consistent with `usedw_o` in the same cycle.

**Thresholds**
- Registers af_thr and ae_thr load from `af_thr_i`/`ae_thr_i` on `thr_we_i`.
- Reset loads `ALMOST_FULL_VALUE` / `ALMOST_EMPTY_VALUE`.
- Values above 2**AWIDTH are legal. Such an af_thr never asserts `almost_full_o`; such an ae_thr keeps `almost_empty_o` always asserted.

**Showahead mode (SHOWAHEAD=1)**
- `empty_o` means "`q_o` holds a valid head word".
- `q_o` always shows the oldest unread word.
- After a read, the next word is shown from the following edge.

**Normal mode (SHOWAHEAD=0)**
- `empty_o` = (`usedw_o` == 0).
- An accepted read loads the oldest word into `q_o` at the next edge.
- Otherwise `q_o` holds its value.

## Timing
**Reset**
- Reset values: `usedw_o`=0, `empty_o`=1, `full_o`=0, `almost_full_o`=0 (with the default threshold), `almost_empty_o`=1, `overflow_o`=0, `underflow_o`=0.
- Reset clears both pointers. RAM contents are not cleared.
- Reset in the middle of traffic discards all stored data. The requests in the reset cycle are ignored.
- `q_o` after reset: X in showahead mode until the first write becomes visible; held value in normal mode.

**Write and flags**
- A write accepted at edge N: `usedw_o`, `full_o` and the almost flags update at N.

**Showahead latency**
- A write into an empty FIFO at edge N: `empty_o` falls at N+1, and `q_o` is valid from N+1 (one cycle of RAM latency).
- A read of the last word at edge N: `empty_o` rises at N.

**Normal-mode latency**
- `empty_o` falls at the same edge N as the write.
- A read accepted at N presents data on `q_o` after N.

**Threshold loads**
- `thr_we_i` at edge N: flags reflect the new thresholds from N+1.

**Edge cases**
- A write and read at the same edge with `usedw_o`=1 in showahead mode: `empty_o` stays 1 for exactly one cycle, then the new word appears.
- Pointer wrap is invisible to the user; order is preserved across wrap.

## Test plan
- Reset, then write 0x01..0x10 (16 words), no reads → `usedw_o`=16, `full_o`=1, `almost_full_o` set from `usedw_o`=12. A 17th `wrreq_i` sets `overflow_o`=1 and `usedw_o` stays 16.
- Full with `ALLOW_RW_WHEN_FULL=1` and `wrreq_i`=`rdreq_i`=1 with data 0xAA → `q_o` advances to 0x02, 0xAA is stored last, `usedw_o`=16, no overflow.
- Empty FIFO with `rdreq_i` pulsed → `underflow_o`=1; `err_clr_i` pulse → `underflow_o`=0. Clear and a new underflow in the same cycle → `underflow_o` stays 1.
- `thr_we_i` with af=4, ae=2, then write 4 words → `almost_full_o` rises when `usedw_o`=4; `almost_empty_o` falls when `usedw_o`=2.
- SHOWAHEAD=0: write 0x5A at N, read at N+1 → `q_o`=0x5A after N+1 and `empty_o`=1 after N+1. SHOWAHEAD=1: the same write gives `q_o`=0x5A and `empty_o`=0 at N+1.
- 3000 cycles of random traffic at read/write mixes 25/75, 50/50 and 75/25, compared every cycle against a scoreboard model, plus `srst_i` asserted while half-full → every output matches its reset value on the next cycle.
